mem_arbiter: RTL

//  Shares one unified memory port between instruction fetch (I side, driven by pc) and data access (D side, driven by dmem).

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between instruction fetch and data access, with alignment checks and a watchdog.
// Latency: grant at the first edge and mem_req the cycle after; completion pulses combinationally with mem_ready (2 cycles minimum).
// Backpressure: requesters hold req until their ready pulse; nothing is queued, and mem_req holds until mem_ready or timeout.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Counter only needs to reach TIMEOUT-1; it saturates at all-ones.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_M1[CW-1:0];

  state_t          state_q, state_d;
  // The last granted side doubles as the owner output and the fairness bit.
  logic            last_d_q, last_d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic            grant_d, grant_i;
  logic            d_bad, i_bad;
  logic            done;
  logic            done_err;
  logic [DW-1:0]   done_rdata;

  assign grant_d = d_req && (!last_d_q || !i_req);
  assign grant_i = !grant_d && i_req;
  assign d_bad   = (d_size == 2'd3) ||
                   ((d_size == 2'd1) && d_addr[0]) ||
                   ((d_size == 2'd2) && (d_addr[1:0] != 2'b00));
  assign i_bad   = (i_addr[1:0] != 2'b00);

  // Next-state logic: arbitration in IDLE, completion / watchdog in the busy states.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done        = 1'b0;
    done_err    = 1'b0;
    done_rdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          last_d_d = 1'b1;
          cnt_d    = '0;
          if (d_bad) begin
            state_d = ERR;
          end else begin
            state_d     = DBUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_size_d  = d_size;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end
        end else if (grant_i) begin
          last_d_d = 1'b0;
          cnt_d    = '0;
          if (i_bad) begin
            state_d = ERR;
          end else begin
            state_d     = IBUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_size_d  = 2'd2;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
          end
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ready) begin
          done       = 1'b1;
          // Stores return zero rather than whatever the memory drives.
          done_rdata = mem_we_q ? '0 : mem_rdata;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          done      = 1'b1;
          done_err  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        done     = 1'b1;
        done_err = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and memory-port registers; reset aborts any transaction without a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Completion is steered to the latched owner only, so both readies are never high together.
  always_comb begin
    i_ready = done && !last_d_q;
    i_err   = done_err && !last_d_q;
    i_rdata = last_d_q ? '0 : done_rdata;
    d_ready = done && last_d_q;
    d_err   = done_err && last_d_q;
    d_rdata = last_d_q ? done_rdata : '0;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = last_d_q;

endmodule
